// File: rtl/router_pkg.sv
// Shared constants for the router datapath register stage: byte width,
// header field layout ({len[5:0], addr[1:0]}) and the reserved address code.
package router_pkg;

  localparam int DATA_WIDTH = 8;

  // Header field layout
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;
  localparam int LEN_LSB  = 2;
  localparam int LEN_W    = 6;

  // Address code that no output port answers to; such headers are ignored
  localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

endpackage

// File: rtl/router_parity_chk.sv
// Running XOR parity over header and payload, received-parity capture and
// the mismatch flag.
// Optional build macro ROUTER_REG_ERR_STICKY_EN: when defined, err is
// sticky until reset; otherwise a new header capture clears it.
module router_parity_chk #(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  clr,
  input  logic                  acc_hdr,
  input  logic [DATA_WIDTH-1:0] hdr_byte,
  input  logic                  acc_data,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  ld_pkt,
  input  logic                  parity_done,
  output logic                  err
);

  logic [DATA_WIDTH-1:0] int_parity_q, int_parity_d;
  logic [DATA_WIDTH-1:0] pkt_parity_q, pkt_parity_d;
  logic                  err_q, err_d;

  // Next-state for the two parity registers and the mismatch flag
  always_comb begin
    int_parity_d = int_parity_q;
    pkt_parity_d = pkt_parity_q;
    err_d        = err_q;

    if (clr) begin
      int_parity_d = '0;
    end else if (acc_hdr) begin
      int_parity_d = int_parity_q ^ hdr_byte;
    end else if (acc_data) begin
      int_parity_d = int_parity_q ^ data_in;
    end

    if (clr) begin
      pkt_parity_d = '0;
    end else if (ld_pkt) begin
      pkt_parity_d = data_in;
    end

`ifdef ROUTER_REG_ERR_STICKY_EN
    // Once a mismatch has been seen it stays flagged until reset
    if (parity_done && (int_parity_q != pkt_parity_q)) begin
      err_d = 1'b1;
    end
`else
    if (clr) begin
      err_d = 1'b0;
    end else if (parity_done) begin
      err_d = (int_parity_q != pkt_parity_q);
    end
`endif
  end

  // Parity state register with synchronous reset
  always_ff @(posedge clock) begin
    if (resetn) begin
      int_parity_q <= '0;
      pkt_parity_q <= '0;
      err_q        <= 1'b0;
    end else begin
      int_parity_q <= int_parity_d;
      pkt_parity_q <= pkt_parity_d;
      err_q        <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/router_reg.sv
// Datapath register stage of the 1-to-3 packet router. Captures the header,
// buffers the byte that arrives while the target FIFO is full, drives the
// FIFO write bus and flags parity mismatches.
// Optional build macro ROUTER_REG_ERR_STICKY_EN (see router_parity_chk).
// Note: resetn is active-high despite its name.
module router_reg #(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  packet_valid,
  input  logic                  fifo_full,
  input  logic                  detect_add,
  input  logic                  ld_state,
  input  logic                  laf_state,
  input  logic                  full_state,
  input  logic                  lfd_state,
  input  logic                  rst_int_reg,
  output logic                  err,
  output logic                  parity_done,
  output logic                  low_packet_valid,
  output logic [DATA_WIDTH-1:0] data_out
);
  import router_pkg::*;

  logic [DATA_WIDTH-1:0] hdr_byte_q, hdr_byte_d;
  logic [DATA_WIDTH-1:0] full_byte_q, full_byte_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  low_pv_q, low_pv_d;
  logic                  pdone_q, pdone_d;

  // State strobes resolved in priority order: detect_add > lfd > ld > laf
  logic hdr_cap, lfd_eff, ld_eff, laf_eff;
  assign hdr_cap = detect_add & packet_valid &
                   (data_in[ADDR_LSB +: ADDR_W] != ADDR_INVALID);
  assign lfd_eff = lfd_state & ~detect_add;
  assign ld_eff  = ld_state  & ~detect_add & ~lfd_state;
  assign laf_eff = laf_state & ~detect_add & ~lfd_state & ~ld_state;

  // Next-state for header, full-byte, output byte and packet status flags
  always_comb begin
    hdr_byte_d  = hdr_byte_q;
    full_byte_d = full_byte_q;
    data_out_d  = data_out_q;
    low_pv_d    = low_pv_q;
    pdone_d     = pdone_q;

    if (hdr_cap) begin
      hdr_byte_d = data_in;
    end

    if (lfd_eff) begin
      data_out_d = hdr_byte_q;
    end else if (ld_eff && !fifo_full) begin
      data_out_d = data_in;
    end else if (ld_eff && fifo_full) begin
      // FIFO cannot take this byte; park it until LOAD_AFTER_FULL
      full_byte_d = data_in;
    end else if (laf_eff) begin
      data_out_d = full_byte_q;
    end

    if (rst_int_reg) begin
      low_pv_d = 1'b0;
    end else if (ld_eff && !packet_valid) begin
      low_pv_d = 1'b1;
    end

    // A parity byte parked by a full FIFO completes on the LAF write instead
    if (hdr_cap) begin
      pdone_d = 1'b0;
    end else if ((ld_eff && !fifo_full && !packet_valid) ||
                 (laf_eff && low_pv_q && !pdone_q)) begin
      pdone_d = 1'b1;
    end
  end

  // Byte and status registers with synchronous reset
  always_ff @(posedge clock) begin
    if (resetn) begin
      hdr_byte_q  <= '0;
      full_byte_q <= '0;
      data_out_q  <= '0;
      low_pv_q    <= 1'b0;
      pdone_q     <= 1'b0;
    end else begin
      hdr_byte_q  <= hdr_byte_d;
      full_byte_q <= full_byte_d;
      data_out_q  <= data_out_d;
      low_pv_q    <= low_pv_d;
      pdone_q     <= pdone_d;
    end
  end

  // The parity byte itself is never accumulated, nor bytes seen in FIFO_FULL
  router_parity_chk #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity_chk (
    .clock       (clock),
    .resetn      (resetn),
    .clr         (hdr_cap),
    .acc_hdr     (lfd_eff),
    .hdr_byte    (hdr_byte_q),
    .acc_data    (ld_eff & packet_valid & ~full_state),
    .data_in     (data_in),
    .ld_pkt      (ld_eff & ~packet_valid),
    .parity_done (pdone_q),
    .err         (err)
  );

  assign data_out         = data_out_q;
  assign parity_done      = pdone_q;
  assign low_packet_valid = low_pv_q;

endmodule

// File: tb/tb_router_reg.sv
// Self-checking bench for router_reg (default build, non-sticky err).
// Expected data_out bytes are queued as each strobe is driven and compared
// against the byte the DUT presents one clock later.
module tb_router_reg;

  logic       clock = 1'b0;
  logic       resetn;
  logic [7:0] data_in;
  logic       packet_valid, fifo_full, detect_add, ld_state, laf_state;
  logic       full_state, lfd_state, rst_int_reg;
  logic       err, parity_done, low_packet_valid;
  logic [7:0] data_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];

  router_reg #(.DATA_WIDTH(8)) dut (
    .clock            (clock),
    .resetn           (resetn),
    .data_in          (data_in),
    .packet_valid     (packet_valid),
    .fifo_full        (fifo_full),
    .detect_add       (detect_add),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .lfd_state        (lfd_state),
    .rst_int_reg      (rst_int_reg),
    .err              (err),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .data_out         (data_out)
  );

  always #5 clock = ~clock;

  // Apply one cycle of inputs, then return 1 time unit after the edge
  task automatic drive(input logic [7:0] d, input logic pv, input logic ff,
                       input logic da, input logic ld, input logic laf,
                       input logic fs, input logic lfd, input logic rir);
    data_in = d; packet_valid = pv; fifo_full = ff; detect_add = da;
    ld_state = ld; laf_state = laf; full_state = fs; lfd_state = lfd;
    rst_int_reg = rir;
    @(posedge clock); #1;
  endtask

  // Header + payload 1..len; payload byte full_idx hits a full FIFO
  task automatic send_packet(input logic [7:0] hdr, input int full_idx);
    logic [7:0] prev;
    logic [7:0] b;
    int len;
    len = int'(hdr[7:2]);
    drive(hdr, 1, 0, 1, 0, 0, 0, 0, 0);
    exp_q.push_back(hdr); drive(hdr, 1, 0, 0, 0, 0, 0, 1, 0); obs_q.push_back(data_out);
    prev = hdr;
    for (int i = 1; i <= len; i++) begin
      b = 8'(i);
      if (i == full_idx) begin
        exp_q.push_back(prev); drive(b, 1, 1, 0, 1, 0, 0, 0, 0); obs_q.push_back(data_out);
        repeat (2) begin
          exp_q.push_back(prev); drive(b, 1, 1, 0, 0, 0, 1, 0, 0); obs_q.push_back(data_out);
        end
        exp_q.push_back(b); drive(b, 1, 0, 0, 0, 1, 0, 0, 0); obs_q.push_back(data_out);
      end else begin
        exp_q.push_back(b); drive(b, 1, 0, 0, 1, 0, 0, 0, 0); obs_q.push_back(data_out);
      end
      prev = b;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b1;
    drive(8'hA5, 1, 1, 1, 1, 1, 1, 1, 1);
    resetn = 1'b0;
    data_in = 8'h00; packet_valid = 0; fifo_full = 0; detect_add = 0;
    ld_state = 0; laf_state = 0; full_state = 0; lfd_state = 0; rst_int_reg = 0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL reset_pdone: got %b expected 0", parity_done); end
    n_checks++; if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lpv: got %b expected 0", low_packet_valid); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h expected 00", data_out); end
  endtask

  task automatic test_good_packet();
    logic [7:0] model;
    logic [7:0] e, o;
    model = 8'h22;
    for (int i = 1; i <= 8; i++) model = model ^ 8'(i);
    send_packet(8'h22, 0);
    exp_q.push_back(8'h2A); drive(8'h2A, 0, 0, 0, 1, 0, 0, 0, 0); obs_q.push_back(data_out);
    n_checks++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL good_pdone: got %b expected 1", parity_done); end
    n_checks++; if (low_packet_valid !== 1'b1) begin n_fail++; $display("FAIL good_lpv: got %b expected 1", low_packet_valid); end
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (err !== (model != 8'h2A)) begin n_fail++; $display("FAIL good_err: got %b expected %b", err, model != 8'h2A); end
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL good_lpv_clr: got %b expected 0", low_packet_valid); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL good_dout: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_fifo_full();
    logic [7:0] e, o;
    send_packet(8'h22, 5);
    exp_q.push_back(8'h2A); drive(8'h2A, 0, 0, 0, 1, 0, 0, 0, 0); obs_q.push_back(data_out);
    n_checks++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL full_pdone: got %b expected 1", parity_done); end
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL full_err: got %b expected 0", err); end
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL full_dout: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_late_parity();
    logic [7:0] e, o;
    send_packet(8'h22, 0);
    exp_q.push_back(8'h08); drive(8'h2A, 0, 1, 0, 1, 0, 0, 0, 0); obs_q.push_back(data_out);
    n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL late_pdone_ld: got %b expected 0", parity_done); end
    n_checks++; if (low_packet_valid !== 1'b1) begin n_fail++; $display("FAIL late_lpv: got %b expected 1", low_packet_valid); end
    exp_q.push_back(8'h08); drive(8'h2A, 0, 1, 0, 0, 0, 1, 0, 0); obs_q.push_back(data_out);
    n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL late_pdone_full: got %b expected 0", parity_done); end
    exp_q.push_back(8'h2A); drive(8'h2A, 0, 0, 0, 0, 1, 0, 0, 0); obs_q.push_back(data_out);
    n_checks++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL late_pdone_laf: got %b expected 1", parity_done); end
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL late_err: got %b expected 0", err); end
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL late_dout: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_bad_parity();
    logic [7:0] e, o;
    send_packet(8'h22, 0);
    exp_q.push_back(8'h00); drive(8'h00, 0, 0, 0, 1, 0, 0, 0, 0); obs_q.push_back(data_out);
    n_checks++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL bad_pdone: got %b expected 1", parity_done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL bad_err_early: got %b expected 0", err); end
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL bad_err: got %b expected 1", err); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks++; if (o !== e) begin n_fail++; $display("FAIL bad_dout: got %h expected %h", o, e); end
    end
  endtask

  task automatic test_invalid_addr();
    drive(8'h23, 1, 0, 1, 0, 0, 0, 0, 0);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL inv_err: got %b expected 1", err); end
    n_checks++; if (parity_done !== 1'b1) begin n_fail++; $display("FAIL inv_pdone: got %b expected 1", parity_done); end
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 1);
    n_checks++; if (low_packet_valid !== 1'b0) begin n_fail++; $display("FAIL inv_lpv_clr: got %b expected 0", low_packet_valid); end
    drive(8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    n_checks++; if (data_out !== 8'h22) begin n_fail++; $display("FAIL inv_hdr_kept: got %h expected 22", data_out); end
  endtask

  task automatic test_header_clear();
    drive(8'h41, 1, 0, 1, 0, 0, 0, 0, 0);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL clr_err: got %b expected 0", err); end
    n_checks++; if (parity_done !== 1'b0) begin n_fail++; $display("FAIL clr_pdone: got %b expected 0", parity_done); end
    drive(8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    n_checks++; if (data_out !== 8'h41) begin n_fail++; $display("FAIL clr_hdr: got %h expected 41", data_out); end
  endtask

  task automatic test_reset_mid();
    drive(8'h66, 1, 0, 0, 1, 0, 0, 0, 0);
    resetn = 1'b1;
    drive(8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 1'b0;
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_dout: got %h expected 00", data_out); end
    drive(8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_hdr: got %h expected 00", data_out); end
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_fifo_full();
    test_late_parity();
    test_bad_parity();
    test_invalid_addr();
    test_header_clear();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/router_reg.md
Name: router_reg

Overview:
- Datapath register stage of the 1-to-3 packet router, between the input port and the FIFO write bus; driven by the router FSM state strobes.
- Holds the header byte and buffers the byte that arrives while the target FIFO is full.
- Computes running XOR parity over header and payload, compares it with the received parity byte, and flags mismatch on err.

Parameters:
- DATA_WIDTH, 8, byte width of data_in/data_out and parity registers.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-high reset (asserted = 1, despite the name); clears all registers.
- data_in  in  8  packet byte: header {len[5:0],addr[1:0]}, payload, then parity.
- packet_valid  in  1  high during header and payload; low on the parity byte.
- fifo_full  in  1  target FIFO full.
- detect_add  in  1  FSM DECODE_ADDRESS state.
- ld_state  in  1  FSM LOAD_DATA state.
- laf_state  in  1  FSM LOAD_AFTER_FULL state.
- full_state  in  1  FSM FIFO_FULL_STATE.
- lfd_state  in  1  FSM LOAD_FIRST_DATA state.
- rst_int_reg  in  1  FSM CHECK_PARITY_ERROR; clears low_packet_valid.
- err  out  1  parity mismatch flag.
- parity_done  out  1  parity byte captured.
- low_packet_valid  out  1  packet_valid fell while loading.
- data_out  out  8  byte to FIFO write bus.

Behaviour:
- Reset: err, parity_done, low_packet_valid and data_out go to 0. Internal hdr_byte, full_byte, int_parity and pkt_parity also go to 0.
- Priority in every cycle: reset > detect_add > lfd_state > ld_state > laf_state > hold.
- Header capture:
  - Condition: detect_add & packet_valid & data_in[1:0] != 2'b11.
  - Effects: hdr_byte <= data_in. int_parity, pkt_parity, parity_done and err are cleared.
  - data_out holds.
- data_out:
  - lfd_state: data_out <= hdr_byte.
  - ld_state & !fifo_full: data_out <= data_in.
  - ld_state & fifo_full: full_byte <= data_in; data_out holds.
  - laf_state: data_out <= full_byte.
  - Otherwise data_out holds.
- Internal parity:
  - lfd_state: int_parity <= int_parity ^ hdr_byte.
  - ld_state & packet_valid & !full_state: int_parity <= int_parity ^ data_in.
  - The parity byte itself is never accumulated.
- Received parity: ld_state & !packet_valid: pkt_parity <= data_in.
- low_packet_valid: set on ld_state & !packet_valid; cleared on rst_int_reg (clear wins if both).
- parity_done:
  - Set on (ld_state & !fifo_full & !packet_valid) or (laf_state & low_packet_valid & !parity_done).
  - Cleared on detect_add; otherwise holds.
- err:
  - In any cycle where parity_done == 1: err <= (int_parity != pkt_parity).
  - err is valid one clock after parity_done rises.
  - Cleared by detect_add; holds otherwise.
- Latency: each data_in byte appears on data_out one clock after its state strobe.
- Reset mid-packet: all state is discarded; the next packet needs detect_add.
- Invalid address 2'b11: the header is not captured, and parity/err are not cleared.

Optional Feature:
- ROUTER_REG_ERR_STICKY_EN:
  - Defined: err, once set, stays 1 until resetn; detect_add does not clear it.
  - Undefined: err is cleared by detect_add as specified above.

Decomposition:
- Package router_pkg: DATA_WIDTH, ADDR_INVALID = 2'b11, header field slices (len[7:2], addr[1:0]).
- Optional sub-module router_parity_chk: holds int_parity, pkt_parity and the err compare.
- Byte/header/full-byte registers remain in router_reg.

Test Plan:
- Reset: resetn=1 for one clock -> err=0, parity_done=0, low_packet_valid=0, data_out=0x00.
- Good packet:
  - Stimulus: header 0x22 (len 8, addr 2), payload 0x01..0x08, parity byte 0x2A, fifo_full=0.
  - Response: data_out sequence 0x22, 0x01..0x08, 0x2A; parity_done=1 after the parity byte; low_packet_valid=1; err=0 next cycle.
- Bad parity: same packet with parity byte 0x00 -> err=1 one clock after parity_done; the next detect_add clears err and parity_done.
- FIFO full:
  - Stimulus: fifo_full=1 during payload 0x05, then full_state for 2 cycles, then laf_state.
  - Response: data_out holds 0x04 until laf_state, then 0x05. Parity is unaffected (final err=0).
- Late parity: parity byte arrives with fifo_full=1 -> parity_done stays 0 until laf_state with low_packet_valid=1, then parity_done=1.
- Invalid address: detect_add with header 0x23 -> hdr_byte unchanged; err/parity_done not cleared; rst_int_reg=1 clears low_packet_valid.
